priority_encoder_seq: RTL and testbench
=======================================

// Module: priority_encoder_seq
// PURPOSE
//  Parametrised sequential priority encoder: accepts an N-bit request vector over a
//  valid/ready handshake and emits the binary index of set bits, either the single
//  highest-priority bit or every set bit, one per beat, in priority order.
//  Sits between request/interrupt collectors and index-driven consumers (mux selects,
//  vector tables); it replaces the fixed 8-to-3 combinational encoder.
// PARAMETERS
//  N          8   request vector width, N >= 2
//  W          $clog2(N)  index width (localparam, not overridable)
//  LSB_FIRST  0   0: highest index has priority; 1: lowest index has priority
//  MODE       0   0 (MODE_SINGLE): one beat per vector; 1 (MODE_ENUM): one beat per set bit
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst_n      in   1  asynchronous reset, active-low
//  en         in   1  enable; low blocks new acceptance only
//  in_valid   in   1  request vector valid
//  in_ready   out  1  block can accept a vector
//  a          in   N  request vector
//  out_valid  out  1  y/flags valid
//  out_ready  in   1  consumer accepts the current beat
//  y          out  W  encoded index of current beat
//  out_last   out  1  final beat of the current vector
//  out_multi  out  1  accepted vector had more than one bit set
//  out_zero   out  1  accepted vector was all-zero
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, pending=0, out_valid=0, y=0, out_last=0,
//    out_multi=0, out_zero=0. Reset mid-burst discards the burst; no beat on release.
//  - FSM IDLE/EMIT. in_ready = en && (state==IDLE); combinational, no in_valid dependence.
//  - IDLE: on in_valid && in_ready at edge k: pending<=a, out_multi<=(popcount(a)>1),
//    out_zero<=(a==0), go EMIT. out_valid is high from cycle k+1 (latency 1).
//  - EMIT: out_valid=1; y = priority index of pending (per LSB_FIRST); all-zero -> y=0.
//    out_last = out_zero | (MODE==0) | (pending has exactly one bit set).
//  - Beat transfer = out_valid && out_ready. On transfer: clear the reported bit in
//    pending; if out_last go IDLE, else stay EMIT with next index on the following cycle.
//  - No same-cycle re-accept: in_ready rises the cycle after the last transfer
//    (max throughput one vector per beats+1 cycles; intended).
//  - Backpressure: while out_valid && !out_ready, y/out_last/out_multi/out_zero held stable.
//  - en low during EMIT: burst completes normally; en only gates IDLE acceptance.
//  - in_valid high with in_ready low: a ignored, no state change.
//  - out_multi/out_zero constant across all beats of one vector.
//  - y, flags driven from registered pending/flags plus the prio_index finder; y=0 when
//    out_valid=0.
// STRUCTURE
//  - Package enc_pkg: typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_e;
//    localparams MODE_SINGLE=0, MODE_ENUM=1.
//  - Sub-module prio_index #(N, LSB_FIRST): combinational; in vec[N-1:0], out idx[W-1:0],
//    out found; used once for pending. One-hot clear mask derived from idx in the parent.
//  - Top holds FSM, pending register, flag registers, handshake logic.
// TESTING (N=8)
//  1 MODE0, a=8'b0010_0100, out_ready=1 -> one beat y=5, out_last=1, out_multi=1,
//    out_zero=0; out_valid exactly 1 cycle after accept; in_ready high next cycle.
//  2 MODE1, a=8'b1000_0101, out_ready=1 -> beats y=7,2,0 on consecutive cycles, out_last
//    only on y=0, out_multi=1 on all; in_ready low through those 3 cycles.
//  3 MODE1, LSB_FIRST=1, a=8'b1000_0101 -> beats y=0,2,7, out_last on y=7.
//  4 a=8'h00 (either mode) -> single beat y=0, out_zero=1, out_last=1, out_multi=0;
//    a=8'h10 -> single beat y=4, out_multi=0.
//  5 MODE1, a=8'hFF, out_ready held low 4 cycles during beat y=6 -> y=6 and flags stable,
//    then beats 5..0 follow; 8 beats total, none dropped or duplicated.
//  6 rst_n low mid-burst (after beat y=7 of 8'h81) -> out_valid=0 immediately, no y=0
//    beat after release; en=0 with in_valid=1 -> in_ready=0 and no beat produced.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and mode constants for the sequential priority encoder.
package enc_pkg;
   typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_e;
   localparam int MODE_SINGLE = 0;
   localparam int MODE_ENUM   = 1;
endpackage

// File: rtl/prio_index.sv
// Combinational priority finder: index of the winning set bit of vec.
// idx is 0 when vec is all-zero; found flags a non-empty vector.
module prio_index #(
   parameter  int N         = 8,
   parameter  int LSB_FIRST = 0,
   localparam int W         = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         found
);

   always_comb begin
      idx   = '0;
      found = |vec;
      // Scan toward the winning end so the last hit is the highest-priority bit.
      for (int i = 0; i < N; i++) begin
         if (LSB_FIRST != 0) begin
            if (vec[N-1-i]) idx = W'(N - 1 - i);
         end else begin
            if (vec[i]) idx = W'(i);
         end
      end
   end

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: takes a request vector over valid/ready and emits
// either the winning index (single mode) or every set index in priority order.
module priority_encoder_seq
   import enc_pkg::*;
#(
   parameter  int N         = 8,
   parameter  int LSB_FIRST = 0,
   parameter  int MODE      = MODE_SINGLE,
   localparam int W         = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y,
   output logic         out_last,
   output logic         out_multi,
   output logic         out_zero
);

   enc_state_e   state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic         multi_q, multi_d;
   logic         zero_q, zero_d;

   logic [W-1:0] idx;
   logic         found;
   logic         one_left;
   logic [N-1:0] clr_mask;

   prio_index #(.N(N), .LSB_FIRST(LSB_FIRST)) u_prio (
      .vec   (pending_q),
      .idx   (idx),
      .found (found)
   );

   assign one_left = found && ((pending_q & (pending_q - N'(1))) == '0);
   assign clr_mask = N'(1) << idx;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      multi_d   = multi_q;
      zero_d    = zero_q;
      in_ready  = en && (state_q == ENC_IDLE);
      out_valid = (state_q == ENC_EMIT);
      y         = (out_valid && found) ? idx : '0;
      out_last  = out_valid && (zero_q || (MODE == MODE_SINGLE) || one_left);
      out_multi = out_valid && multi_q;
      out_zero  = out_valid && zero_q;
      case (state_q)
         ENC_IDLE: begin
            if (in_valid && in_ready) begin
               pending_d = a;
               multi_d   = ((a & (a - N'(1))) != '0);
               zero_d    = (a == '0);
               state_d   = ENC_EMIT;
            end
         end
         ENC_EMIT: begin
            // Last transfer returns to IDLE; acceptance reopens one cycle later.
            if (out_ready) begin
               pending_d = pending_q & ~clr_mask;
               if (out_last) state_d = ENC_IDLE;
            end
         end
         default: state_d = ENC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ENC_IDLE;
         pending_q <= '0;
         multi_q   <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         multi_q   <= multi_d;
         zero_q    <= zero_d;
      end
   end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Scoreboard bench: four encoder configurations (MODE x LSB_FIRST) driven in lock-step
// with directed then random vectors, a mid-burst reset and an enable-low window.
module tb_priority_encoder_seq;

   typedef struct {
      int y;
      bit last;
      bit multi;
      bit zero;
   } beat_t;
   typedef beat_t beat_q_t[$];

   logic clk = 1'b0;
   logic rst_n;
   int   tcyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] dir_vec [6] = '{8'h24, 8'h85, 8'h00, 8'h10, 8'hFF, 8'h81};

   always #5 clk = ~clk;
   always @(posedge clk) tcyc <= tcyc + 1;

   task automatic chk(input int cfg, input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL cfg%0d %s at cycle %0d: got %0d expected %0d", cfg, nm, tcyc, act, exp);
      end
   endtask

   // Reference: set-bit positions listed in priority order, one beat each (or just the first).
   function automatic beat_q_t model(input logic [7:0] v, input int md, input int lb);
      beat_q_t r;
      int      ix[$];
      beat_t   b;
      for (int i = 0; i < 8; i++) begin
         int k;
         k = (lb != 0) ? i : 7 - i;
         if (v[k]) ix.push_back(k);
      end
      if (ix.size() == 0) begin
         b = '{0, 1'b1, 1'b0, 1'b1};
         r.push_back(b);
         return r;
      end
      foreach (ix[j]) begin
         b.y     = ix[j];
         b.multi = (ix.size() > 1);
         b.zero  = 1'b0;
         b.last  = (md == 0) || (j == ix.size() - 1);
         r.push_back(b);
         if (md == 0) break;
      end
      return r;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : cfg
      localparam int MD = g / 2;
      localparam int LB = g % 2;
      logic       en, in_valid, in_ready, out_valid, out_ready, out_last, out_multi, out_zero;
      logic [7:0] a;
      logic [2:0] y;
      beat_t      q[$];
      beat_q_t    tmp;
      bit         acc;
      logic [7:0] acc_a;
      int         di;

      priority_encoder_seq #(.N(8), .LSB_FIRST(LB), .MODE(MD)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .a         (a),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .y         (y),
         .out_last  (out_last),
         .out_multi (out_multi),
         .out_zero  (out_zero)
      );

      initial begin : drv
         en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0;
         acc = 1'b0; acc_a = '0; di = 0;
         forever begin
            @(negedge clk);
            if (acc) begin
               tmp = model(acc_a, MD, LB);
               foreach (tmp[j]) q.push_back(tmp[j]);
               acc = 1'b0;
            end
            #1;
            if (tcyc < 4 || (tcyc >= 300 && tcyc < 330) || (tcyc > 331 && tcyc < 346) || tcyc >= 351) begin
               en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
            end else if (tcyc < 300) begin
               if (di < 6) begin
                  en = 1'b1; in_valid = 1'b1; a = dir_vec[di]; out_ready = 1'b1;
               end else begin
                  en       = ($urandom % 8) != 0;
                  in_valid = $urandom % 2;
                  case ($urandom % 4)
                     0: a = 8'($urandom);
                     1: a = 8'h00;
                     2: a = 8'(1 << ($urandom % 8));
                     default: a = 8'hFF;
                  endcase
                  out_ready = ((tcyc / 50) % 2 != 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
               end
            end else if (tcyc == 330) begin
               en = 1'b1; in_valid = 1'b1; a = 8'h81; out_ready = 1'b1;
            end else if (tcyc == 331) begin
               in_valid = 1'b0;
            end else begin
               en = 1'b0; in_valid = 1'b1; a = 8'($urandom);
            end
            #1;
            if (in_valid && in_ready && rst_n) begin
               acc = 1'b1; acc_a = a;
               if (tcyc < 300 && di < 6) di++;
            end
            if (tcyc == 331) begin
               // First beat of 8'h81 transfers on this edge; reset lands just after it.
               @(posedge clk);
               #1 q.delete();
               #1 chk(g, "rst_mid_out_valid", out_valid, 0);
            end
         end
      end

      initial begin : mon
         forever begin
            @(negedge clk);
            #3;
            chk(g, "out_valid", out_valid, q.size() > 0);
            chk(g, "in_ready", in_ready, en && (q.size() == 0));
            if (out_valid && q.size() > 0) begin
               chk(g, "y", y, q[0].y);
               chk(g, "out_last", out_last, q[0].last);
               chk(g, "out_multi", out_multi, q[0].multi);
               chk(g, "out_zero", out_zero, q[0].zero);
               if (out_ready) void'(q.pop_front());
            end else begin
               chk(g, "y_idle", y, 0);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      #23 rst_n = 1'b1;
      wait (tcyc == 332);
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait (tcyc == 356);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: cycle %0d reached time limit, expected finish by cycle 356", tcyc);
      $fatal(1, "watchdog");
   end

endmodule
